reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard_pkg.sv | 16 +
 rtl/reg_scoreboard_sb_entry.sv | 73 +++++++
 rtl/reg_scoreboard.sv | 94 +++++++++
 tb/tb_reg_scoreboard.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// ============================================================================
// Module : reg_scoreboard_pkg
// Brief  : Shared widths and constants for the register scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_scoreboard_pkg;
    localparam int REG_IDX_W          = 5;
    localparam int NUM_REGS           = 1 << REG_IDX_W;
    localparam logic [REG_IDX_W-1:0] X0_IDX = '0;
    localparam int CNT_W              = 2;
    localparam int LOAD_USE_STALL_DEF = 1;
endpackage

`default_nettype wire

// File: rtl/reg_scoreboard_sb_entry.sv
// ============================================================================
// Module : sb_entry
// Brief  : In-flight writer count and load-wait countdown for one register.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_entry
    import reg_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec_wb,
    input  logic             dec_flush,
    input  logic             load_set,
    input  logic             load_clr,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] ldw,
    output logic             ovf
);
    localparam logic [CNT_W:0] c_cnt_max = {1'b0, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_ldw;
    logic [CNT_W:0]   w_up;
    logic [CNT_W:0]   w_dec;
    logic [CNT_W:0]   w_diff;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_ldw_nxt;
    logic             w_ovf;

    // Net change is resolved first, then clamped, so issue+WB on a full counter is not an overflow.
    always_comb begin
        w_up      = {1'b0, r_cnt} + {{CNT_W{1'b0}}, inc};
        w_dec     = {{CNT_W{1'b0}}, dec_wb} + {{CNT_W{1'b0}}, dec_flush};
        w_diff    = '0;
        w_cnt_nxt = '0;
        w_ovf     = 1'b0;
        if (w_up >= w_dec) begin
            w_diff = w_up - w_dec;
            if (w_diff > c_cnt_max) begin
                w_cnt_nxt = c_cnt_max[CNT_W-1:0];
                w_ovf     = 1'b1;
            end else begin
                w_cnt_nxt = w_diff[CNT_W-1:0];
            end
        end
    end

    always_comb begin
        w_ldw_nxt = (r_ldw != '0) ? r_ldw - 1'b1 : r_ldw;
        if (load_set) w_ldw_nxt = load_val;
        if (load_clr) w_ldw_nxt = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_ldw <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_ldw <= w_ldw_nxt;
        end
    end

    assign cnt = r_cnt;
    assign ldw = r_ldw;
    assign ovf = w_ovf;
endmodule

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// Module : reg_scoreboard
// Brief  : Per-register hazard scoreboard producing load-use stall and issue.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int LOAD_USE_STALL = LOAD_USE_STALL_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_reg_write,
    input  logic                 id_mem_read,
    input  logic                 ex_flush,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_reg_write,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic                 wb_reg_write,
    output logic                 stall,
    output logic                 issue,
    output logic                 pipe_empty,
    output logic                 sb_overflow
);
    localparam logic [CNT_W-1:0] c_load_val = CNT_W'(LOAD_USE_STALL);

    logic [CNT_W-1:0]    w_cnt [NUM_REGS];
    logic [CNT_W-1:0]    w_ldw [NUM_REGS];
    logic [NUM_REGS-1:0] w_ovf;
    logic                w_stall;
    logic                w_issue;
    logic                w_empty;
    logic                r_sb_overflow;

    // x0 carries no state, so its slot reads as permanently idle.
    assign w_cnt[0] = '0;
    assign w_ldw[0] = '0;
    assign w_ovf[0] = 1'b0;

    generate
        for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
            logic w_hit_id;
            logic w_hit_ex;
            assign w_hit_id = w_issue && id_reg_write && (id_rd == REG_IDX_W'(r));
            assign w_hit_ex = ex_flush && ex_reg_write && (ex_rd == REG_IDX_W'(r));

            sb_entry u_entry (
                .clk       (clk),
                .reset     (reset),
                .inc       (w_hit_id),
                .dec_wb    (wb_reg_write && (wb_rd == REG_IDX_W'(r))),
                .dec_flush (w_hit_ex),
                .load_set  (w_hit_id && id_mem_read),
                .load_clr  (w_hit_ex && ex_mem_read),
                .load_val  (c_load_val),
                .cnt       (w_cnt[r]),
                .ldw       (w_ldw[r]),
                .ovf       (w_ovf[r])
            );
        end
    endgenerate

    always_comb begin
        w_stall = id_valid && !ex_flush &&
                  ((id_use_rs1 && (id_rs1 != X0_IDX) && (w_ldw[id_rs1] != '0)) ||
                   (id_use_rs2 && (id_rs2 != X0_IDX) && (w_ldw[id_rs2] != '0)));
        w_issue = id_valid && !w_stall && !ex_flush;
        w_empty = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_cnt[i] != '0) w_empty = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_sb_overflow <= 1'b0;
        else        r_sb_overflow <= r_sb_overflow | (|w_ovf);
    end

    assign stall       = w_stall;
    assign issue       = w_issue;
    assign pipe_empty  = w_empty;
    assign sb_overflow = r_sb_overflow;
endmodule

`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
// ============================================================================
// Module : tb_reg_scoreboard
// Brief  : Directed self-checking bench for reg_scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_scoreboard;
    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_flush, ex_reg_write, ex_mem_read;
    logic [4:0] ex_rd;
    logic [4:0] wb_rd;
    logic       wb_reg_write;
    logic       stall, issue, pipe_empty, sb_overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .ex_flush     (ex_flush),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .stall        (stall),
        .issue        (issue),
        .pipe_empty   (pipe_empty),
        .sb_overflow  (sb_overflow)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = 0; id_reg_write = 0; id_mem_read = 0;
        ex_flush = 0; ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
        wb_rd = 0; wb_reg_write = 0;
    endtask

    task automatic id_instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                            input logic u2, input logic [4:0] rd, input logic rw, input logic mr);
        id_valid = 1; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr;
    endtask

    // Advance one edge, then return 2 time units later so inputs change away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        idle();
        reset = 0;
        id_valid = 1;
        #3;
        check("rst_stall", stall, 0);
        check("rst_issue", issue, 1);
        check("rst_empty", pipe_empty, 1);
        check("rst_ovf", sb_overflow, 0);
        tick(); tick();
        reset = 1;
        idle();

        // Load then immediately dependent add: one bubble.
        id_instr(0, 0, 0, 0, 5, 1, 1);
        #1; check("lu_ld_issue", issue, 1); check("lu_ld_stall", stall, 0);
        tick();
        id_instr(5, 1, 1, 1, 6, 1, 0);
        #1; check("lu_dep_stall", stall, 1); check("lu_dep_issue", issue, 0);
        tick();
        #1; check("lu_dep_stall2", stall, 0); check("lu_dep_issue2", issue, 1);
        tick();
        idle();
        #1; check("lu_cnt5", dut.w_cnt[5], 1); check("lu_cnt6", dut.w_cnt[6], 1);
        check("lu_busy", pipe_empty, 0);
        wb_rd = 5; wb_reg_write = 1; tick();
        wb_rd = 6; tick();
        idle();
        #1; check("lu_empty", pipe_empty, 1);

        // ALU producer: no stall, count held until WB.
        id_instr(0, 0, 0, 0, 5, 1, 0);
        tick();
        id_instr(5, 1, 0, 0, 0, 1, 0);
        #1; check("alu_stall", stall, 0); check("alu_issue", issue, 1);
        tick();
        idle();
        #1; check("alu_cnt5", dut.w_cnt[5], 1); check("alu_busy", pipe_empty, 0);
        wb_rd = 5; wb_reg_write = 1; tick();
        idle();
        #1; check("alu_cnt5_wb", dut.w_cnt[5], 0); check("alu_empty", pipe_empty, 1);

        // Load to x0 carries no hazard.
        id_instr(0, 0, 0, 0, 0, 1, 1);
        #1; check("x0_ld_issue", issue, 1);
        tick();
        id_instr(0, 1, 0, 1, 0, 0, 0);
        #1; check("x0_stall", stall, 0); check("x0_empty", pipe_empty, 1);
        tick();
        idle();
        #1; check("x0_empty2", pipe_empty, 1);

        // Flushed load releases its dependent and its count.
        id_instr(0, 0, 0, 0, 7, 1, 1);
        tick();
        id_instr(7, 1, 0, 0, 0, 0, 0);
        ex_flush = 1; ex_rd = 7; ex_reg_write = 1; ex_mem_read = 1;
        #1; check("fl_stall", stall, 0); check("fl_issue", issue, 0);
        tick();
        ex_flush = 0; ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
        #1; check("fl_dep_stall", stall, 0); check("fl_dep_issue", issue, 1);
        check("fl_cnt7", dut.w_cnt[7], 0); check("fl_empty", pipe_empty, 1);
        tick();
        idle();

        // Counter saturation and sticky overflow on x9.
        id_instr(0, 0, 0, 0, 9, 1, 0);
        tick(); tick(); tick();
        #1; check("ov_cnt9_3", dut.w_cnt[9], 3); check("ov_flag_pre", sb_overflow, 0);
        tick();
        #1; check("ov_flag", sb_overflow, 1); check("ov_cnt9_sat", dut.w_cnt[9], 3);
        wb_rd = 9; wb_reg_write = 1;
        tick();
        idle();
        #1; check("ov_same_cycle", dut.w_cnt[9], 3);
        wb_rd = 9; wb_reg_write = 1;
        tick();
        #1; check("ov_wb1", dut.w_cnt[9], 2);
        tick(); tick(); tick();
        idle();
        #1; check("ov_underflow", dut.w_cnt[9], 0); check("ov_empty", pipe_empty, 1);
        check("ov_sticky", sb_overflow, 1);

        // Reset in the middle of a load-use stall.
        id_instr(0, 0, 0, 0, 5, 1, 1);
        tick();
        id_instr(5, 1, 0, 0, 6, 1, 0);
        #1; check("mr_stall_pre", stall, 1);
        reset = 0;
        #1; check("mr_stall", stall, 0); check("mr_issue", issue, 1);
        check("mr_empty", pipe_empty, 1); check("mr_ovf", sb_overflow, 0);
        tick();
        reset = 1;
        id_instr(5, 1, 0, 0, 0, 0, 0);
        #1; check("mr_after_stall", stall, 0);
        tick();
        idle();
        #1; check("mr_after_empty", pipe_empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
